// File: rtl/muldiv_pkg.sv
// Constants shared by the sequential multiplier and divider in the execute slot.
package muldiv_pkg;

    localparam int unsigned W          = 32;
    localparam int unsigned SW         = 6;
    localparam int unsigned S_LOAD     = 0;
    localparam int unsigned S_DONE     = W + 1;
    localparam int unsigned S_MUL_DONE = W - 1;

    // Terminal counter value of the divider for an arbitrary operand width.
    function automatic int unsigned div_done_state(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare, subtract.
module div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] r,
    input  logic         qmsb,
    input  logic [W-1:0] y,
    output logic [W-1:0] r_next,
    output logic         qbit
);

    logic [W:0] t;

    always_comb begin
        t    = {r, qmsb};
        qbit = (t >= {1'b0, y});
        // When the subtraction is taken the true difference is below y, so W bits suffice.
        r_next = qbit ? (t[W-1:0] - y) : t[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider for DIV/MOD: W+1 stall cycles, floored signed mode.
module seq_divider
    import muldiv_pkg::*;
#(
    parameter int unsigned W  = muldiv_pkg::W,
    parameter int unsigned SW = muldiv_pkg::SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          u,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    output logic          stall,
    output logic [W-1:0]  quot,
    output logic [W-1:0]  rem
);

    localparam logic [SW-1:0] S_LD = SW'(S_LOAD);
    localparam logic [SW-1:0] S_DN = SW'(div_done_state(W));

    logic [SW-1:0] s;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  q_acc;
    logic          neg;
    logic          dz;

    logic [W-1:0]  r_nx;
    logic          qbit;
    logic          xneg;
    logic          done;

    div_step #(.W(W)) u_step (
        .r      (r_acc),
        .qmsb   (q_acc[W-1]),
        .y      (y),
        .r_next (r_nx),
        .qbit   (qbit)
    );

    always_comb begin
        xneg  = u & x[W-1];
        // Reset masks the done state so stall reads as run while rst is high.
        done  = ~rst & (s == S_DN);
        stall = run & ~done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            r_acc <= '0;
            q_acc <= '0;
            neg   <= 1'b0;
            dz    <= 1'b0;
        end else begin
            if (!run) begin
                s <= S_LD;
            end else if (s != S_DN) begin
                s <= s + 1'b1;
            end

            if (run && (s == S_LD)) begin
                q_acc <= xneg ? -x : x;
                r_acc <= '0;
                neg   <= xneg;
                dz    <= (y == '0);
            end else if (run && (s != S_DN)) begin
                r_acc <= r_nx;
                q_acc <= {q_acc[W-2:0], qbit};
            end
        end
    end

    // Magnitude result is corrected to floored form when the dividend was negative.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (done) begin
            if (dz) begin
                quot = '1;
                rem  = x;
            end else if (!neg) begin
                quot = q_acc;
                rem  = r_acc;
            end else if (r_acc == '0) begin
                quot = -q_acc;
                rem  = '0;
            end else begin
                quot = ~q_acc;
                rem  = y - r_acc;
            end
        end
    end

endmodule
